// File: rtl/oled_phase_seq_if.sv
// Phase-source and IIC write-channel bundle shared by oled_phase_seq and whatever surrounds it.
interface oled_phase_seq_if #(
    parameter int N_PH = 4,
    parameter int DW   = 24,
    parameter int CPW  = (N_PH > 1) ? $clog2(N_PH) : 1
);
    logic [N_PH-1:0]         trig;
    logic [N_PH-1:0]         ph_req;
    logic [N_PH-1:0]         ph_valid;
    logic [N_PH-1:0][DW-1:0] ph_data;
    logic [N_PH-1:0]         ph_ack;
    logic [N_PH-1:0]         ph_finish;
    logic                    iic_wr_req;
    logic [DW-1:0]           iic_wr_data;
    logic                    iic_wr_done;
    logic [CPW-1:0]          cur_phase;
    logic                    boot_done;
    logic                    busy;
    logic                    err;

    modport master (
        input  trig, ph_valid, ph_data, ph_finish, iic_wr_done,
        output ph_req, ph_ack, iic_wr_req, iic_wr_data, cur_phase, boot_done, busy, err
    );

    modport slave (
        output trig, ph_valid, ph_data, ph_finish, iic_wr_done,
        input  ph_req, ph_ack, iic_wr_req, iic_wr_data, cur_phase, boot_done, busy, err
    );
endinterface

// File: rtl/oled_phase_seq.sv
// OLED phase sequencer: runs boot phases once in order, then triggered update phases by
// lowest-index priority, relaying one IIC word at a time with a per-word watchdog.
module oled_phase_seq #(
    parameter int N_PH    = 4,
    parameter int BOOT_PH = 3,
    parameter int DW      = 24,
    parameter int TO_MAX  = 1000000,
    parameter int TO_W    = 20
) (
    input  logic             sys_clk,
    input  logic             rst,
    oled_phase_seq_if.master bus
);
    localparam int CPW = (N_PH > 1) ? $clog2(N_PH) : 1;
    localparam int BW  = $clog2(BOOT_PH + 1);
    localparam logic [TO_W-1:0] WD_LIM = TO_W'(TO_MAX - 1);

    function automatic logic [N_PH-1:0] upd_mask();
        logic [N_PH-1:0] m;
        m = '0;
        for (int i = BOOT_PH; i < N_PH; i++) m[i] = 1'b1;
        return m;
    endfunction
    localparam logic [N_PH-1:0] UPD_MASK = upd_mask();

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_ISSUE, S_WAIT, S_DONE, S_ERR} state_e;

    state_e          state_q;
    logic [N_PH-1:0] pend_q, pend_d;
    logic [BW-1:0]   boot_idx_q;
    logic [TO_W-1:0] wd_q;
    logic            retrig_q;
    logic [N_PH-1:0] ph_req_q, ph_ack_q;
    logic            iic_wr_req_q;
    logic [DW-1:0]   iic_wr_data_q;
    logic [CPW-1:0]  cur_phase_q;
    logic            boot_done_q, busy_q, err_q;

    logic [N_PH-1:0] trig_upd;
    logic [CPW-1:0]  pend_first, idle_sel;
    logic            idle_go, in_run;

    assign trig_upd = bus.trig & UPD_MASK;
    assign in_run   = (state_q == S_RUN) || (state_q == S_ISSUE) || (state_q == S_WAIT);

    always_comb begin
        pend_first = '0;
        for (int i = N_PH - 1; i >= 0; i--)
            if (pend_q[i]) pend_first = CPW'(i);
        idle_go  = 1'b0;
        idle_sel = '0;
        if (int'(boot_idx_q) < BOOT_PH) begin
            idle_go  = 1'b1;
            idle_sel = CPW'(boot_idx_q);
        end else if (|pend_q) begin
            idle_go  = 1'b1;
            idle_sel = pend_first;
        end
        // A trigger seen during the run (retrig_q) or on the finishing edge keeps the bit
        // set so the phase runs once more; otherwise the serviced request is retired.
        pend_d = pend_q;
        if (state_q == S_DONE && UPD_MASK[cur_phase_q] && !retrig_q)
            pend_d[cur_phase_q] = 1'b0;
        pend_d = pend_d | trig_upd;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pend_q        <= '0;
            boot_idx_q    <= '0;
            wd_q          <= '0;
            retrig_q      <= 1'b0;
            ph_req_q      <= '0;
            ph_ack_q      <= '0;
            iic_wr_req_q  <= 1'b0;
            iic_wr_data_q <= '0;
            cur_phase_q   <= '0;
            boot_done_q   <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            ph_ack_q     <= '0;
            iic_wr_req_q <= 1'b0;
            if (in_run && trig_upd[cur_phase_q]) retrig_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (idle_go) begin
                        cur_phase_q <= idle_sel;
                        ph_req_q    <= N_PH'(1) << idle_sel;
                        retrig_q    <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.ph_finish[cur_phase_q]) begin
                        ph_req_q <= '0;
                        state_q  <= S_DONE;
                    end else if (bus.ph_valid[cur_phase_q]) begin
                        iic_wr_data_q <= bus.ph_data[cur_phase_q];
                        state_q       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    iic_wr_req_q <= 1'b1;
                    wd_q         <= '0;
                    state_q      <= S_WAIT;
                end
                S_WAIT: begin
                    wd_q <= wd_q + 1'b1;
                    if (bus.iic_wr_done) begin
                        ph_ack_q <= N_PH'(1) << cur_phase_q;
                        state_q  <= S_RUN;
                    end else if (wd_q == WD_LIM) begin
                        ph_req_q <= '0;
                        state_q  <= S_ERR;
                    end
                end
                S_DONE: begin
                    if (!UPD_MASK[cur_phase_q]) begin
                        boot_idx_q <= boot_idx_q + 1'b1;
                        if (int'(boot_idx_q) + 1 == BOOT_PH) boot_done_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_ERR: begin
                    // Panel state is unknown after a stalled write, so the whole boot reruns.
                    err_q       <= 1'b1;
                    boot_idx_q  <= '0;
                    boot_done_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ph_req      = ph_req_q;
    assign bus.ph_ack      = ph_ack_q;
    assign bus.iic_wr_req  = iic_wr_req_q;
    assign bus.iic_wr_data = iic_wr_data_q;
    assign bus.cur_phase   = cur_phase_q;
    assign bus.boot_done   = boot_done_q;
    assign bus.busy        = busy_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_oled_phase_seq.sv
// Directed bench for oled_phase_seq: word-counting source models, a fixed-latency IIC
// responder, a table of trigger scenarios and hand-written multi-cycle corner cases.
module tb_oled_phase_seq;
    localparam int NP   = 5;
    localparam int DLAT = 10;

    logic sys_clk;
    logic rst;

    oled_phase_seq_if #(.N_PH(NP), .DW(24)) bus ();

    oled_phase_seq #(
        .N_PH(NP), .BOOT_PH(3), .DW(24), .TO_MAX(50), .TO_W(6)
    ) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int checks = 0;
    int failures = 0;

    int words[NP] = '{2, 2, 2, 2, 1};
    int w3_cur = 2;
    int cnt[NP];
    int cd = 0;
    bit stall_en = 0;
    logic [NP-1:0] prev_req = '0;
    int order[$];
    logic [23:0] iic_log[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int wtot(input int p);
        return (p == 3) ? w3_cur : words[p];
    endfunction

    // Sources: present the next word while selected, finish once all words are acked.
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            bus.ph_valid[i]  = bus.ph_req[i] && (cnt[i] != 0);
            bus.ph_finish[i] = bus.ph_req[i] && (cnt[i] == 0);
            bus.ph_data[i]   = {8'h3C, 8'(i), 8'(((i == 3) ? w3_cur : words[i]) - cnt[i])};
        end
    end

    // IIC responder and phase monitor, both working on the falling edge.
    initial bus.iic_wr_done = 1'b0;
    always @(negedge sys_clk) begin
        int idx;
        bus.iic_wr_done = 1'b0;
        if (rst) begin
            cd = 0;
            prev_req = '0;
        end else begin
            if (cd != 0) begin
                cd--;
                if (cd == 0) bus.iic_wr_done = 1'b1;
            end
            if (bus.iic_wr_req) begin
                iic_log.push_back(bus.iic_wr_data);
                if (!(stall_en && bus.ph_req[3])) cd = DLAT;
            end
            for (int i = 0; i < NP; i++)
                if (bus.ph_ack[i] && cnt[i] > 0) cnt[i]--;
            if (bus.ph_req != '0 && bus.ph_req != prev_req) begin
                idx = 0;
                for (int i = 0; i < NP; i++) if (bus.ph_req[i]) idx = i;
                order.push_back(idx);
                cnt[idx] = wtot(idx);
                chk("req_onehot", 64'($onehot(bus.ph_req)), 64'd1);
                chk("cur_phase_vs_req", 64'(bus.cur_phase), 64'(idx));
            end
            prev_req = bus.ph_req;
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.trig = '0;
        stall_en = 0;
        step();
        step();
        order.delete();
        iic_log.delete();
        for (int i = 0; i < NP; i++) cnt[i] = 0;
        rst = 1'b0;
    endtask

    typedef struct {
        string         name;
        int            trig_at;
        logic [NP-1:0] trig_val;
        int            w3;
        int            n_exp;
        logic [31:0]   exp_order;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [23:0] exp_log[$];
        int p, k;
        bit found, seen3, fired;

        vecs[0] = '{"boot_only",        -1, 5'b00000, 2, 3, 32'h00000210};
        vecs[1] = '{"trig_in_boot",      0, 5'b01000, 2, 4, 32'h00003210};
        vecs[2] = '{"prio_3_before_4",   0, 5'b11000, 2, 5, 32'h00043210};
        vecs[3] = '{"boot_bits_ignored", 0, 5'b10111, 2, 4, 32'h00004210};
        vecs[4] = '{"zero_word_phase",  20, 5'b01000, 0, 4, 32'h00003210};
        vecs[5] = '{"trig_after_boot", 150, 5'b10000, 2, 4, 32'h00004210};

        rst = 1'b1;
        bus.trig = '0;
        for (int i = 0; i < NP; i++) cnt[i] = 0;
        step();
        step();
        chk("rst_ph_req", 64'(bus.ph_req), 64'd0);
        chk("rst_ph_ack", 64'(bus.ph_ack), 64'd0);
        chk("rst_iic_req", 64'(bus.iic_wr_req), 64'd0);
        chk("rst_iic_data", 64'(bus.iic_wr_data), 64'd0);
        chk("rst_cur_phase", 64'(bus.cur_phase), 64'd0);
        chk("rst_flags", 64'({bus.boot_done, bus.busy, bus.err}), 64'd0);

        // Latency of the first word.
        do_reset();
        step();
        chk("lat_req_after_idle", 64'(bus.ph_req), 64'h1);
        chk("lat_busy", 64'(bus.busy), 64'd1);
        step();
        chk("lat_no_req_in_issue", 64'(bus.iic_wr_req), 64'd0);
        step();
        chk("lat_iic_req", 64'(bus.iic_wr_req), 64'd1);
        chk("lat_iic_data", 64'(bus.iic_wr_data), 64'h3C0000);
        step();
        chk("lat_iic_req_pulse", 64'(bus.iic_wr_req), 64'd0);
        repeat (9) step();
        chk("lat_no_early_ack", 64'(bus.ph_ack), 64'd0);
        step();
        chk("lat_ack", 64'(bus.ph_ack), 64'h1);
        step();
        chk("lat_ack_pulse", 64'(bus.ph_ack), 64'd0);

        // Table-driven trigger scenarios.
        foreach (vecs[v]) begin
            w3_cur = vecs[v].w3;
            do_reset();
            for (int c = 0; c < 300; c++) begin
                bus.trig = (c == vecs[v].trig_at) ? vecs[v].trig_val : '0;
                step();
            end
            bus.trig = '0;
            chk({vecs[v].name, "_nphases"}, 64'(order.size()), 64'(vecs[v].n_exp));
            exp_log.delete();
            for (int j = 0; j < vecs[v].n_exp; j++) begin
                p = int'(vecs[v].exp_order[4*j +: 4]);
                if (j < order.size())
                    chk($sformatf("%s_order%0d", vecs[v].name, j), 64'(order[j]), 64'(p));
                for (int w = 0; w < wtot(p); w++) exp_log.push_back({8'h3C, 8'(p), 8'(w)});
            end
            chk({vecs[v].name, "_nwords"}, 64'(iic_log.size()), 64'(exp_log.size()));
            for (int j = 0; j < exp_log.size() && j < iic_log.size(); j++)
                chk($sformatf("%s_word%0d", vecs[v].name, j), 64'(iic_log[j]), 64'(exp_log[j]));
            chk({vecs[v].name, "_boot_done"}, 64'(bus.boot_done), 64'd1);
            chk({vecs[v].name, "_idle"}, 64'({bus.busy, bus.err}), 64'd0);
        end
        w3_cur = 2;

        // Re-trigger during the IIC wait of phase 3.
        do_reset();
        bus.trig = 5'b01000;
        step();
        bus.trig = '0;
        fired = 0;
        for (int c = 0; c < 300; c++) begin
            if (!fired && bus.ph_req[3] && bus.iic_wr_req) begin
                bus.trig = 5'b01000;
                fired = 1;
            end else bus.trig = '0;
            step();
        end
        bus.trig = '0;
        chk("retrig_wait_fired", 64'(fired), 64'd1);
        chk("retrig_wait_nphases", 64'(order.size()), 64'd5);
        if (order.size() == 5) chk("retrig_wait_last", 64'(order[4]), 64'd3);

        // Re-trigger on the finishing cycle of phase 3.
        do_reset();
        bus.trig = 5'b01000;
        step();
        bus.trig = '0;
        fired = 0;
        seen3 = 0;
        for (int c = 0; c < 300; c++) begin
            if (!fired && seen3 && bus.ph_req == '0 && bus.busy) begin
                bus.trig = 5'b01000;
                fired = 1;
            end else bus.trig = '0;
            seen3 = bus.ph_req[3];
            step();
        end
        bus.trig = '0;
        chk("retrig_done_fired", 64'(fired), 64'd1);
        chk("retrig_done_nphases", 64'(order.size()), 64'd5);
        if (order.size() == 5) chk("retrig_done_last", 64'(order[4]), 64'd3);

        // Watchdog: phase 3 write never completes.
        do_reset();
        stall_en = 1;
        bus.trig = 5'b01000;
        step();
        bus.trig = '0;
        found = 0;
        for (int c = 0; c < 400 && !found; c++) begin
            step();
            if (bus.ph_req[3] && bus.iic_wr_req) found = 1;
        end
        chk("wd_reached_stalled_write", 64'(found), 64'd1);
        chk("wd_boot_done_before", 64'(bus.boot_done), 64'd1);
        k = 0;
        for (int c = 0; c < 200; c++) begin
            step();
            k++;
            if (bus.ph_req == '0) break;
        end
        stall_en = 0;
        chk("wd_latency", 64'(k), 64'd50);
        chk("wd_busy_in_err", 64'(bus.busy), 64'd1);
        step();
        chk("wd_err_set", 64'(bus.err), 64'd1);
        chk("wd_boot_done_cleared", 64'(bus.boot_done), 64'd0);
        chk("wd_idle_after_err", 64'({bus.busy, bus.ph_req}), 64'd0);
        step();
        chk("wd_reboot_phase0", 64'(bus.ph_req), 64'h1);
        repeat (300) step();
        chk("wd_nphases", 64'(order.size()), 64'd8);
        if (order.size() == 8) begin
            chk("wd_order4", 64'(order[4]), 64'd0);
            chk("wd_order7", 64'(order[7]), 64'd3);
        end
        chk("wd_err_sticky", 64'(bus.err), 64'd1);
        chk("wd_reboot_done", 64'(bus.boot_done), 64'd1);
        do_reset();
        chk("wd_err_cleared_by_rst", 64'(bus.err), 64'd0);

        // Reset in the middle of a write.
        do_reset();
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            if (bus.iic_wr_req) found = 1;
        end
        chk("rstmid_saw_req", 64'(found), 64'd1);
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("rstmid_ph_req", 64'(bus.ph_req), 64'd0);
        chk("rstmid_data", 64'(bus.iic_wr_data), 64'd0);
        chk("rstmid_flags", 64'({bus.busy, bus.err, bus.boot_done, bus.ph_ack, bus.cur_phase}), 64'd0);
        for (int c = 0; c < 4; c++) begin
            chk("rstmid_no_iic_req", 64'(bus.iic_wr_req), 64'd0);
            step();
        end
        order.delete();
        iic_log.delete();
        rst = 1'b0;
        step();
        chk("rstmid_restart_phase0", 64'(bus.ph_req), 64'h1);
        repeat (120) step();
        chk("rstmid_boot_done", 64'(bus.boot_done), 64'd1);
        chk("rstmid_nphases", 64'(order.size()), 64'd3);
        chk("rstmid_first_word", 64'((iic_log.size() > 0) ? iic_log[0] : 24'hFFFFFF), 64'h3C0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/oled_phase_seq.md
Name: oled_phase_seq

Overview:
Parametrised successor to the fixed OLED top-level sequencer. It serves N_PH phase-source blocks: first the boot phases (init, refresh, static text) run once in order, then the update phases (sensor data and similar) run on triggers. The block arbitrates which source drives the single IIC write channel and relays the per-word write handshake. Unlike the fixed version, it latches triggers that arrive while busy, arbitrates by priority, and recovers from a stalled IIC via a watchdog.

Parameters:
N_PH, 4, total phase sources (index 0..N_PH-1)
BOOT_PH, 3, phases 0..BOOT_PH-1 run once after reset in index order; must satisfy 1 <= BOOT_PH <= N_PH
DW, 24, IIC word width: {slave addr[23:16], ctrl/reg[15:8], data[7:0]}
TO_MAX, 1000000, watchdog limit in sys_clk cycles per IIC word
TO_W, 20, watchdog counter width; must satisfy 2^TO_W > TO_MAX

Ports:
sys_clk  in  1  system clock
rst  in  1  synchronous active-high reset
trig  in  N_PH  per-phase update trigger, single-cycle pulse; bits below BOOT_PH ignored
ph_req  out  N_PH  one-hot, selected source is active
ph_valid  in  N_PH  source has a word on ph_data
ph_data  in  N_PH*DW  source words, slice i = [i*DW +: DW]
ph_ack  out  N_PH  one-cycle pulse, word accepted by IIC (write done)
ph_finish  in  N_PH  source has no more words
iic_wr_req  out  1  one-cycle write request
iic_wr_data  out  DW  registered word, stable from request until done
iic_wr_done  in  1  one-cycle IIC completion pulse
cur_phase  out  $clog2(N_PH) (min 1)  selected index
boot_done  out  1  all boot phases completed
busy  out  1  state != S_IDLE
err  out  1  sticky watchdog flag

Behaviour:
- One clock, sys_clk. Synchronous active-high rst.
- Reset values: ph_req=0, ph_ack=0, iic_wr_req=0, iic_wr_data=0, cur_phase=0, boot_done=0, busy=0, err=0, pending=0, boot_idx=0, wd=0, state=S_IDLE.
- pending[N_PH] register:
  - trig[i] sets pending[i] for i >= BOOT_PH, including during boot and while phase i is running.
  - The S_DONE clear of pending[sel] loses to a simultaneous set, so that phase re-runs.
- S_IDLE:
  - If boot_idx < BOOT_PH: sel = boot_idx, go to S_RUN.
  - Else if pending != 0: sel = lowest set index, go to S_RUN.
  - Else stay.
  - cur_phase is updated on the same edge as the transition.
- S_RUN:
  - ph_req[sel] = 1.
  - If ph_finish[sel]: go to S_DONE. Finish has priority over valid.
  - Else if ph_valid[sel]: iic_wr_data <= slice sel, go to S_ISSUE.
- S_ISSUE: iic_wr_req = 1 for exactly one cycle, wd <= 0, go to S_WAIT.
- S_WAIT:
  - wd increments each cycle.
  - On iic_wr_done: ph_ack[sel] pulses 1 cycle (the cycle after done), go to S_RUN.
  - Sources must drop or refresh ph_valid on ack; the sequencer re-samples only in S_RUN.
  - Else if wd == TO_MAX-1: go to S_ERR.
  - iic_wr_done outside S_WAIT is ignored.
- S_DONE (1 cycle):
  - ph_req = 0.
  - If sel < BOOT_PH: boot_idx++; boot_done <= 1 when boot_idx reaches BOOT_PH.
  - Else clear pending[sel].
  - Go to S_IDLE.
- S_ERR (1 cycle):
  - err <= 1, ph_req = 0.
  - boot_idx <= 0, boot_done <= 0: the full boot re-runs, because OLED state is unknown after a stall.
  - pending is kept. Go to S_IDLE.
- ph_req outside S_RUN/S_ISSUE/S_WAIT is 0.
- Latency: S_IDLE->ph_req is 1 cycle; valid->iic_wr_req is 2 cycles; done->ack is 1 cycle.
- A phase with zero words is legal (finish in the first S_RUN cycle) and costs 3 cycles.
- rst mid-transfer aborts at once with no IIC request; the IIC driver is reset by the same rst.

Test Plan:
- Boot order (N_PH=4, BOOT_PH=3): each source supplies 2 words, done returns 10 cycles after req -> ph_req one-hot 0,1,2 in sequence, 6 iic_wr_req pulses, iic_wr_data matches slices, boot_done=1 after phase 2 finishes, phase 3 not run.
- Trigger during boot: trig[3] pulsed in the first cycle after rst release -> phase 3 runs immediately after boot_done rises; pending[3] then 0.
- Re-trigger while running: trig[3] pulsed during S_WAIT of phase 3, and again on the S_DONE cycle -> phase 3 runs exactly one more time in each case.
- Priority (N_PH=5, BOOT_PH=3): trig[4] and trig[3] in the same cycle -> phase 3 runs first, then phase 4.
- Watchdog (TO_MAX=50): iic_wr_done withheld -> S_ERR reached 50 cycles after iic_wr_req; err=1 sticky, boot_done=0, boot restarts at phase 0, err cleared only by rst.
- Reset mid-write: rst asserted during S_WAIT -> all outputs at reset values the next cycle, boot restarts at phase 0 after release, no iic_wr_req seen while rst is high.
